// File: rtl/manual_drive_pkg.sv
// rtl/manual_drive_pkg.sv - shared encodings for the manual-driving control core
package manual_drive_pkg;

    typedef enum logic [1:0] {
        ST_NOT_STARTING = 2'b00,
        ST_STARTING     = 2'b01,
        ST_MOVING       = 2'b10
    } state_t;

    localparam int MV_FWD   = 0;
    localparam int MV_BWD   = 1;
    localparam int MV_LEFT  = 2;
    localparam int MV_RIGHT = 3;

    // Upper two bits of the byte the car top level sends to the simulated device.
    localparam logic [1:0] UART_HEADER = 2'b10;

endpackage

// File: rtl/manual_drive_if.sv
// rtl/manual_drive_if.sv - driver switches in, power/state/motion/indicators out
interface manual_drive_if;
    logic       power_on;
    logic       power_off;
    logic       clutch;
    logic       throttle;
    logic       brake;
    logic       rgs;
    logic       left;
    logic       right;
    logic       power;
    logic [1:0] state;
    logic [3:0] moving_state;
    logic       turn_left_light;
    logic       turn_right_light;

    modport master (
        output power_on, power_off, clutch, throttle, brake, rgs, left, right,
        input  power, state, moving_state, turn_left_light, turn_right_light
    );

    modport slave (
        input  power_on, power_off, clutch, throttle, brake, rgs, left, right,
        output power, state, moving_state, turn_left_light, turn_right_light
    );
endinterface

// File: rtl/manual_drive_hold_timer.sv
// rtl/manual_drive_hold_timer.sv - long-press counter, done pulses on the CYCLES-th enabled cycle
module manual_drive_hold_timer #(
    parameter int unsigned CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic done
);
    localparam int unsigned CNT_W = $clog2(CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    assign done = en && (cnt == CNT_W'(CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!en || done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/manual_drive.sv
// rtl/manual_drive.sv - switch synchronisers, power control and driving-state FSM
module manual_drive
    import manual_drive_pkg::*;
#(
    parameter int unsigned POWER_ON_CYCLES = 100_000_000
) (
    input  logic           clk,
    input  logic           rst,
    manual_drive_if.slave  bus
);
    logic [7:0] raw, sync1, sync2;
    logic       on_s, off_s, clu_s, thr_s, brk_s, rgs_s, left_s, right_s;
    logic       rgs_q;
    logic       hold_en, hold_done;

    logic       power_q, power_n;
    state_t     state_q, state_n;
    logic [3:0] mv_q, mv_n;
    logic       ll_q, ll_n, lr_q, lr_n;
    logic       stall;

    assign raw = {bus.power_on, bus.power_off, bus.clutch, bus.throttle,
                  bus.brake, bus.rgs, bus.left, bus.right};
    assign {on_s, off_s, clu_s, thr_s, brk_s, rgs_s, left_s, right_s} = sync2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            rgs_q <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rgs_q <= rgs_s;
        end
    end

    assign hold_en = on_s && !power_q && !off_s;

    manual_drive_hold_timer #(
        .CYCLES (POWER_ON_CYCLES)
    ) u_hold_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (hold_en),
        .done (hold_done)
    );

    always_comb begin
        power_n = power_q;
        state_n = state_q;
        stall   = 1'b0;
        mv_n    = '0;
        if (off_s) begin
            power_n = 1'b0;
            state_n = ST_NOT_STARTING;
        end else if (!power_q) begin
            state_n = ST_NOT_STARTING;
            if (hold_done) power_n = 1'b1;
        end else begin
            case (state_q)
                ST_NOT_STARTING: begin
                    if (thr_s && !brk_s) begin
                        if (clu_s) state_n = ST_STARTING;
                        else       stall   = 1'b1;
                    end
                end
                ST_STARTING: begin
                    if (thr_s && !clu_s && !brk_s) state_n = ST_MOVING;
                end
                ST_MOVING: begin
                    // Shifting gear without the clutch stalls the engine outright.
                    if (rgs_s != rgs_q && !clu_s) stall   = 1'b1;
                    else if (brk_s)               state_n = ST_NOT_STARTING;
                    else if (clu_s || !thr_s)     state_n = ST_STARTING;
                end
                default: state_n = ST_NOT_STARTING;
            endcase
            if (stall) begin
                power_n = 1'b0;
                state_n = ST_NOT_STARTING;
            end
        end
        if (power_n && state_n == ST_MOVING) begin
            mv_n[MV_FWD]   = !rgs_s;
            mv_n[MV_BWD]   = rgs_s;
            mv_n[MV_LEFT]  = left_s && !right_s;
            mv_n[MV_RIGHT] = right_s && !left_s;
        end
        ll_n = power_n && left_s;
        lr_n = power_n && right_s;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            power_q <= 1'b0;
            state_q <= ST_NOT_STARTING;
            mv_q    <= '0;
            ll_q    <= 1'b0;
            lr_q    <= 1'b0;
        end else begin
            power_q <= power_n;
            state_q <= state_n;
            mv_q    <= mv_n;
            ll_q    <= ll_n;
            lr_q    <= lr_n;
        end
    end

    assign bus.power            = power_q;
    assign bus.state            = state_q;
    assign bus.moving_state     = mv_q;
    assign bus.turn_left_light  = ll_q;
    assign bus.turn_right_light = lr_q;
endmodule

// File: tb/tb_manual_drive.sv
// tb/tb_manual_drive.sv - vector table plus scoreboard bench for manual_drive
module tb_manual_drive;

    typedef struct packed {
        logic clutch;
        logic throttle;
        logic brake;
        logic rgs;
        logic left;
        logic right;
    } in_t;

    typedef struct packed {
        logic       power;
        logic [1:0] state;
        logic [3:0] mv;
        logic       ll;
        logic       lr;
    } out_t;

    typedef struct {
        string name;
        in_t   in;
        out_t  exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    manual_drive_if bus ();

    manual_drive #(
        .POWER_ON_CYCLES (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    out_t  sb[$];
    int    vectors    = 0;
    int    miscompares = 0;
    vec_t  tbl[12];

    localparam out_t OFF = {1'b0, 2'b00, 4'b0000, 1'b0, 1'b0};
    localparam out_t IDLE = {1'b1, 2'b00, 4'b0000, 1'b0, 1'b0};

    task automatic drive(input in_t i);
        bus.clutch   = i.clutch;
        bus.throttle = i.throttle;
        bus.brake    = i.brake;
        bus.rgs      = i.rgs;
        bus.left     = i.left;
        bus.right    = i.right;
    endtask

    task automatic check_now(input string name);
        out_t got, e;
        got = {bus.power, bus.state, bus.moving_state, bus.turn_left_light, bus.turn_right_light};
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            if (got !== e) begin
                miscompares++;
                $display("FAIL %s: got power=%b state=%b mv=%b ll=%b lr=%b, expected power=%b state=%b mv=%b ll=%b lr=%b",
                         name, got.power, got.state, got.mv, got.ll, got.lr,
                         e.power, e.state, e.mv, e.ll, e.lr);
            end
        end
    endtask

    task automatic settle_check(input string name, input out_t e);
        sb.push_back(e);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_now(name);
    endtask

    task automatic hold_power_on(input int n);
        bus.power_on = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        bus.power_on = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{"start",      6'b110000, {1'b1, 2'b01, 4'b0000, 1'b0, 1'b0}};
        tbl[1]  = '{"move_fwd",   6'b010000, {1'b1, 2'b10, 4'b0001, 1'b0, 1'b0}};
        tbl[2]  = '{"left",       6'b010010, {1'b1, 2'b10, 4'b0101, 1'b1, 1'b0}};
        tbl[3]  = '{"left_right", 6'b010011, {1'b1, 2'b10, 4'b0001, 1'b1, 1'b1}};
        tbl[4]  = '{"right",      6'b010001, {1'b1, 2'b10, 4'b1001, 1'b0, 1'b1}};
        tbl[5]  = '{"brake",      6'b011000, {1'b1, 2'b00, 4'b0000, 1'b0, 1'b0}};
        tbl[6]  = '{"restart",    6'b110000, {1'b1, 2'b01, 4'b0000, 1'b0, 1'b0}};
        tbl[7]  = '{"move_again", 6'b010000, {1'b1, 2'b10, 4'b0001, 1'b0, 1'b0}};
        tbl[8]  = '{"rev_clutch", 6'b110100, {1'b1, 2'b01, 4'b0000, 1'b0, 1'b0}};
        tbl[9]  = '{"rev_move",   6'b010100, {1'b1, 2'b10, 4'b0010, 1'b0, 1'b0}};
        tbl[10] = '{"rgs_stall",  6'b010000, OFF};
        tbl[11] = '{"ignored",    6'b110011, OFF};

        bus.power_on  = 1'b0;
        bus.power_off = 1'b0;
        drive(6'b000000);
        repeat (2) @(negedge clk);
        sb.push_back(OFF);
        check_now("reset");
        rst = 1'b1;

        hold_power_on(9);
        settle_check("hold_9", OFF);
        hold_power_on(10);
        settle_check("hold_10", IDLE);

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].in);
            settle_check(tbl[i].name, tbl[i].exp);
        end

        drive(6'b000000);
        hold_power_on(10);
        settle_check("power_up2", IDLE);
        drive(6'b010000);
        settle_check("stall", OFF);

        drive(6'b000000);
        hold_power_on(12);
        settle_check("power_up3", IDLE);
        drive(6'b110000);
        settle_check("start3", {1'b1, 2'b01, 4'b0000, 1'b0, 1'b0});
        drive(6'b010010);
        settle_check("move3", {1'b1, 2'b10, 4'b0101, 1'b1, 1'b0});
        #2 rst = 1'b0;
        sb.push_back(OFF);
        #1 check_now("async_reset");
        @(negedge clk);
        rst = 1'b1;

        drive(6'b000000);
        hold_power_on(10);
        settle_check("power_up4", IDLE);
        drive(6'b110000);
        settle_check("start4", {1'b1, 2'b01, 4'b0000, 1'b0, 1'b0});
        bus.power_off = 1'b1;
        settle_check("power_off", OFF);
        bus.power_off = 1'b0;
        repeat (20) @(negedge clk);
        sb.push_back(OFF);
        check_now("stays_off");
        drive(6'b000000);
        hold_power_on(10);
        settle_check("power_up5", IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
